// File: rtl/store_unit.sv
// store_unit: turns one sb/sh/sw request into 1, 2 or 4 little-endian byte
// writes on an 8-bit data memory port, one byte per cycle.
module store_unit #(
  parameter int unsigned ADDR_W      = 8,
  parameter bit          ALIGN_CHECK = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_size,
  input  logic [31:0]       req_base,
  input  logic [15:0]       req_offset,
  input  logic [31:0]       req_data,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_ERR   = 2'd2
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [1:0]        r_k, w_k_nxt;
  logic [1:0]        r_last, w_last_nxt;
  logic [ADDR_W-1:0] r_ea, w_ea_nxt;
  logic [31:0]       r_data, w_data_nxt;

  logic              r_mem_we, w_mem_we_nxt;
  logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_nxt;
  logic [7:0]        r_mem_wdata, w_mem_wdata_nxt;
  logic              r_done, w_done_nxt;
  logic              r_err, w_err_nxt;

  logic [ADDR_W-1:0] w_ea_in;
  logic [1:0]        w_last_in;
  logic              w_size_ok;
  logic              w_misaligned;
  logic [1:0]        w_k_inc;

  function automatic logic [7:0] pick_byte(input logic [31:0] d, input logic [1:0] k);
    logic [7:0] b;
    case (k)
      2'd0:    b = d[7:0];
      2'd1:    b = d[15:8];
      2'd2:    b = d[23:16];
      default: b = d[31:24];
    endcase
    return b;
  endfunction

  // Full 32-bit sum, truncated to the memory address width.
  assign w_ea_in = ADDR_W'(req_base + {16'b0, req_offset});
  assign w_k_inc = r_k + 2'd1;

  // Decode the incoming request: byte count (as N-1), legality, alignment.
  always_comb begin
    w_last_in    = 2'd0;
    w_size_ok    = 1'b1;
    w_misaligned = 1'b0;
    case (req_size)
      2'b00:   w_last_in = 2'd0;
      2'b01:   w_last_in = 2'd1;
      2'b10:   w_last_in = 2'd3;
      default: w_size_ok = 1'b0;
    endcase
    if (ALIGN_CHECK) begin
      if (req_size == 2'b01)
        w_misaligned = w_ea_in[0];
      else if (req_size == 2'b10)
        w_misaligned = |w_ea_in[1:0];
    end
  end

  // Next state plus next values of the registered memory-port outputs.
  // Outputs are loaded on the same edge that enters the state they belong
  // to, so the byte presented for index k is computed one cycle ahead.
  always_comb begin
    w_state_nxt     = r_state;
    w_k_nxt         = r_k;
    w_last_nxt      = r_last;
    w_ea_nxt        = r_ea;
    w_data_nxt      = r_data;
    w_mem_we_nxt    = 1'b0;
    w_mem_addr_nxt  = '0;
    w_mem_wdata_nxt = '0;
    w_done_nxt      = 1'b0;
    w_err_nxt       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          w_ea_nxt   = w_ea_in;
          w_data_nxt = req_data;
          w_last_nxt = w_last_in;
          w_k_nxt    = 2'd0;
          if (!w_size_ok || w_misaligned) begin
            w_state_nxt = S_ERR;
            w_err_nxt   = 1'b1;
          end else begin
            w_state_nxt     = S_WRITE;
            w_mem_we_nxt    = 1'b1;
            w_mem_addr_nxt  = w_ea_in;
            w_mem_wdata_nxt = req_data[7:0];
            w_done_nxt      = (w_last_in == 2'd0);
          end
        end
      end
      S_WRITE: begin
        if (r_k == r_last) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_k_nxt         = w_k_inc;
          w_mem_we_nxt    = 1'b1;
          w_mem_addr_nxt  = r_ea + ADDR_W'(w_k_inc);
          w_mem_wdata_nxt = pick_byte(r_data, w_k_inc);
          w_done_nxt      = (w_k_inc == r_last);
        end
      end
      S_ERR: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State and output registers; synchronous reset aborts any store in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_k         <= '0;
      r_last      <= '0;
      r_ea        <= '0;
      r_data      <= '0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_k         <= w_k_nxt;
      r_last      <= w_last_nxt;
      r_ea        <= w_ea_nxt;
      r_data      <= w_data_nxt;
      r_mem_we    <= w_mem_we_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
      r_done      <= w_done_nxt;
      r_err       <= w_err_nxt;
    end
  end

  assign req_ready = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign done      = r_done;
  assign err       = r_err;

endmodule
